// File: rtl/dmem_responder.sv
// Data-memory responder: req/ack handshake, byte-enabled writes, word reads, LATENCY wait states.
// Optional macro DMEM_RANGE_CHECK_EN adds an err output and blocks out-of-range accesses.
module dmem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int LATENCY    = 2
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    req,
  input  logic                    d_rw,
  input  logic [31:0]             daddr,
  input  logic [DATA_WIDTH-1:0]   ddata_w,
  input  logic [DATA_WIDTH/8-1:0] dbe,
`ifdef DMEM_RANGE_CHECK_EN
  output logic                    err,
`endif
  output logic                    ack,
  output logic [DATA_WIDTH-1:0]   ddata_r,
  output logic                    busy
);

  // state  | meaning
  // IDLE   | waiting for req; request fields are captured on accept
  // WAIT   | counting down wait states
  // RESP   | ack pulse; write committed / read data registered on entry

  localparam int NB = DATA_WIDTH / 8;
  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [3:0] LAT = 4'(LATENCY);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [DATA_WIDTH-1:0] RAM [0:MEM_DEPTH-1];

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  rw_q, rw_d;
  logic [31:0]           addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NB-1:0]         be_q, be_d;
  logic                  ack_q, ack_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  sel_idle;
  logic                  cur_rw;
  logic [31:0]           cur_addr;
  logic [DATA_WIDTH-1:0] cur_wdata;
  logic [NB-1:0]         cur_be;
  logic [AW-1:0]         idx;
  logic                  commit;
  logic                  in_range;
  logic                  wr_en;
  logic                  unused_addr_bits;

  // With LATENCY=0 the commit happens on the accept edge, so the live inputs stand in for the captured copy.
  always_comb begin
    sel_idle  = (state_q == S_IDLE);
    cur_rw    = sel_idle ? d_rw    : rw_q;
    cur_addr  = sel_idle ? daddr   : addr_q;
    cur_wdata = sel_idle ? ddata_w : wdata_q;
    cur_be    = sel_idle ? dbe     : be_q;
    idx       = cur_addr[AW+1:2];
    commit    = (sel_idle && req && (LAT == 4'd0)) ||
                ((state_q == S_WAIT) && (cnt_q == 4'd1));
`ifdef DMEM_RANGE_CHECK_EN
    in_range  = (cur_addr[31:AW+2] == '0);
`else
    in_range  = 1'b1;
`endif
    wr_en     = RESET_N && commit && cur_rw && in_range;
  end

  assign unused_addr_bits = ^{cur_addr[1:0], cur_addr[31:AW+2]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    ack_d   = commit;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          rw_d    = d_rw;
          addr_d  = daddr;
          wdata_d = ddata_w;
          be_d    = dbe;
          if (LAT == 4'd0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = LAT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (commit && !cur_rw) rdata_d = in_range ? RAM[idx] : '0;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  // RAM is deliberately outside the reset domain; contents survive RESET_N.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (cur_be[i]) RAM[idx][8*i +: 8] <= cur_wdata[8*i +: 8];
      end
    end
  end

`ifdef DMEM_RANGE_CHECK_EN
  logic err_q;
  always_ff @(posedge CLK) begin
    if (!RESET_N) err_q <= 1'b0;
    else          err_q <= commit && !in_range;
  end
  assign err = err_q;
`endif

  assign ack     = ack_q;
  assign ddata_r = rdata_q;
  assign busy    = (state_q != S_IDLE);

endmodule
